// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : MEM-stage data-memory slave. Accepts one word/byte load or store
//            at a time, waits LATENCY cycles, then performs the access and
//            pulses done. Holds the pipeline via a combinational stall.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              byte_en,
  input  logic              is_unsigned,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int         c_depth    = 2 ** (ADDR_W - 1);
  localparam logic [2:0] c_cnt_init = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic                r_rd;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_be;
  logic                r_us;
  logic [DATA_W-1:0]   r_mem [0:c_depth-1];

  logic                w_req;
  logic                w_from_idle;
  logic                w_acc_rd;
  logic                w_acc_wr;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_acc_be;
  logic                w_acc_us;
  logic                w_acc_err;
  logic                w_do_access;
  logic [ADDR_W-2:0]   w_idx;
  logic [DATA_W-1:0]   w_word;
  logic [7:0]          w_byte;
  logic [DATA_W-1:0]   w_rd_result;

  assign w_req = mem_read | mem_write;

  // With zero latency the access happens on the accepting edge, so it must
  // use the live request inputs; otherwise it uses the latched copy.
  assign w_from_idle = (r_state == IDLE);
  assign w_acc_rd    = w_from_idle ? mem_read    : r_rd;
  assign w_acc_wr    = w_from_idle ? mem_write   : r_wr;
  assign w_acc_addr  = w_from_idle ? addr        : r_addr;
  assign w_acc_wdata = w_from_idle ? wdata       : r_wdata;
  assign w_acc_be    = w_from_idle ? byte_en     : r_be;
  assign w_acc_us    = w_from_idle ? is_unsigned : r_us;

  // Conflicting op or misaligned word access is consumed but not performed.
  assign w_acc_err = (w_acc_rd & w_acc_wr) | (~w_acc_be & w_acc_addr[0]);

  assign w_do_access = ~reset &
                       (((r_state == IDLE) & w_req & (LATENCY == 0)) |
                        ((r_state == BUSY) & (r_cnt == 3'd0)));

  // Load path: select the lane and extend it for byte loads.
  assign w_idx       = w_acc_addr[ADDR_W-1:1];
  assign w_word      = r_mem[w_idx];
  assign w_byte      = w_acc_addr[0] ? w_word[15:8] : w_word[7:0];
  assign w_rd_result = w_acc_be ? {(w_acc_us ? 8'h00 : {8{w_byte[7]}}), w_byte}
                                : w_word;

  // Stall while a request is being accepted or the wait counter runs.
  assign stall = ((r_state == IDLE) & w_req) | (r_state == BUSY);

  // Array store: word or single-lane byte write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_do_access && w_acc_wr && !w_acc_err) begin
      if (!w_acc_be) begin
        r_mem[w_idx] <= w_acc_wdata;
      end else if (w_acc_addr[0]) begin
        r_mem[w_idx][15:8] <= w_acc_wdata[7:0];
      end else begin
        r_mem[w_idx][7:0] <= w_acc_wdata[7:0];
      end
    end
  end

  // Control FSM with registered completion outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 1'b0;
      r_us    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_rd    <= mem_read;
            r_wr    <= mem_write;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= byte_en;
            r_us    <= is_unsigned;
            r_cnt   <= c_cnt_init;
            r_state <= (LATENCY == 0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // Request inputs are still high here; never re-accept them.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_do_access) begin
        done <= 1'b1;
        err  <= w_acc_err;
        if (w_acc_rd && !w_acc_err) begin
          rdata <= w_rd_result;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (LATENCY=2 and
//            LATENCY=0 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk;
  logic        reset;

  logic        rd0, wr0, be0, us0;
  logic [7:0]  a0;
  logic [15:0] wd0;
  logic        stall0, done0, err0;
  logic [15:0] rdata0;

  logic        rd1, wr1, be1, us1;
  logic [7:0]  a1;
  logic [15:0] wd1;
  logic        stall1, done1, err1;
  logic [15:0] rdata1;

  int tests;
  int fails;

  logic [15:0] r_rd;
  logic        r_err;

  dmem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0), .addr(a0),
    .wdata(wd0), .byte_en(be0), .is_unsigned(us0), .stall(stall0),
    .done(done0), .rdata(rdata0), .err(err0)
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1), .addr(a1),
    .wdata(wd1), .byte_en(be1), .is_unsigned(us1), .stall(stall1),
    .done(done1), .rdata(rdata1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic rd, input logic wr, input logic [7:0] a,
                         input logic [15:0] wd, input logic be, input logic us);
    if (sel) begin
      rd1 = rd; wr1 = wr; a1 = a; wd1 = wd; be1 = be; us1 = us;
    end else begin
      rd0 = rd; wr0 = wr; a0 = a; wd0 = wd; be0 = be; us0 = us;
    end
  endtask

  // One full access: checks stall length, done cycle, and single done pulse.
  task automatic do_access(input string tag, input bit sel, input logic rd, input logic wr,
                           input logic [7:0] a, input logic [15:0] wd, input logic be,
                           input logic us, input int lat,
                           output logic [15:0] rdo, output logic erro);
    int n_stall;
    int done_cyc;
    logic stall_at_done;
    n_stall = 0;
    done_cyc = -1;
    stall_at_done = 1'bx;
    rdo = 16'hxxxx;
    erro = 1'bx;
    @(posedge clk); #1;
    set_req(sel, rd, wr, a, wd, be, us);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (sel ? done1 : done0) begin
        done_cyc = c;
        stall_at_done = sel ? stall1 : stall0;
        rdo = sel ? rdata1 : rdata0;
        erro = sel ? err1 : err0;
        break;
      end
      if (sel ? stall1 : stall0) n_stall++;
    end
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(lat + 1));
    check({tag, "_stall_cycles"}, 32'(n_stall), 32'(lat + 1));
    check({tag, "_stall_at_done"}, {31'd0, stall_at_done}, 32'd0);
    // Request still held: the DONE->IDLE cycle must not produce another pulse.
    @(negedge clk);
    check({tag, "_single_done"}, {31'd0, (sel ? done1 : done0)}, 32'd0);
    set_req(sel, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_err", {31'd0, err0}, 32'd0);
    check("rst_rdata", {16'd0, rdata0}, 32'h0000);
    check("rst_rdata_l0", {16'd0, rdata1}, 32'h0000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Word write then read
    do_access("wr_beef", 1'b0, 1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 2, r_rd, r_err);
    check("wr_beef_err", {31'd0, r_err}, 32'd0);
    check("wr_beef_rdata_kept", {16'd0, r_rd}, 32'h0000);
    do_access("rd_beef", 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 2, r_rd, r_err);
    check("rd_beef_data", {16'd0, r_rd}, 32'hBEEF);
    check("rd_beef_err", {31'd0, r_err}, 32'd0);

    // Byte lanes
    do_access("wr_1234", 1'b0, 1'b0, 1'b1, 8'h20, 16'h1234, 1'b0, 1'b0, 2, r_rd, r_err);
    do_access("wrb_9c", 1'b0, 1'b0, 1'b1, 8'h21, 16'h559C, 1'b1, 1'b0, 2, r_rd, r_err);
    check("wrb_9c_err", {31'd0, r_err}, 32'd0);
    do_access("rd_9c34", 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 2, r_rd, r_err);
    check("rd_9c34_data", {16'd0, r_rd}, 32'h9C34);
    do_access("rdb_s", 1'b0, 1'b1, 1'b0, 8'h21, 16'h0000, 1'b1, 1'b0, 2, r_rd, r_err);
    check("rdb_signed", {16'd0, r_rd}, 32'hFF9C);
    do_access("rdb_u", 1'b0, 1'b1, 1'b0, 8'h21, 16'h0000, 1'b1, 1'b1, 2, r_rd, r_err);
    check("rdb_unsigned", {16'd0, r_rd}, 32'h009C);
    do_access("rdb_lo", 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0, 2, r_rd, r_err);
    check("rdb_low_lane", {16'd0, r_rd}, 32'h0034);

    // Errors
    do_access("mis_rd", 1'b0, 1'b1, 1'b0, 8'h11, 16'h0000, 1'b0, 1'b0, 2, r_rd, r_err);
    check("mis_rd_err", {31'd0, r_err}, 32'd1);
    check("mis_rd_rdata_kept", {16'd0, r_rd}, 32'h0034);
    do_access("both", 1'b0, 1'b1, 1'b1, 8'h10, 16'h0000, 1'b0, 1'b0, 2, r_rd, r_err);
    check("both_err", {31'd0, r_err}, 32'd1);
    check("both_rdata_kept", {16'd0, r_rd}, 32'h0034);
    do_access("mis_wr", 1'b0, 1'b0, 1'b1, 8'h11, 16'h1111, 1'b0, 1'b0, 2, r_rd, r_err);
    check("mis_wr_err", {31'd0, r_err}, 32'd1);
    do_access("rd_after_err", 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 2, r_rd, r_err);
    check("rd_after_err_data", {16'd0, r_rd}, 32'hBEEF);
    check("rd_after_err_err", {31'd0, r_err}, 32'd0);

    // Reset mid-BUSY discards a pending write
    do_access("wr_5555", 1'b0, 1'b0, 1'b1, 8'h30, 16'h5555, 1'b0, 1'b0, 2, r_rd, r_err);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b1, 8'h30, 16'hAAAA, 1'b0, 1'b0);
    @(negedge clk);
    check("rstmid_c0_stall", {31'd0, stall0}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("rstmid_c1_busy_stall", {31'd0, stall0}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_stall", {31'd0, stall0}, 32'd0);
    check("rstmid_done", {31'd0, done0}, 32'd0);
    repeat (4) @(negedge clk);
    check("rstmid_no_late_done", {31'd0, done0}, 32'd0);
    do_access("rd_5555", 1'b0, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 2, r_rd, r_err);
    check("rd_5555_data", {16'd0, r_rd}, 32'h5555);

    // LATENCY=0 instance
    do_access("l0_wr", 1'b1, 1'b0, 1'b1, 8'h04, 16'h4321, 1'b0, 1'b0, 0, r_rd, r_err);
    check("l0_wr_err", {31'd0, r_err}, 32'd0);
    do_access("l0_rd", 1'b1, 1'b1, 1'b0, 8'h04, 16'h0000, 1'b0, 1'b0, 0, r_rd, r_err);
    check("l0_rd_data", {16'd0, r_rd}, 32'h4321);
    do_access("l0_rdb", 1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 1'b0, 0, r_rd, r_err);
    check("l0_rdb_data", {16'd0, r_rd}, 32'h0043);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
